axi_lite_master_cmd: RTL and testbench
======================================

Name: axi_lite_master_cmd

Overview:
- Synthesizable AXI4-Lite initiator (master). It converts a simple command/response stream into single-beat AXI4-Lite reads and writes.
- It sits between local control logic and any AXI4-Lite register slave in the IP catalog. It is the RTL counterpart of the VIP master used in our slave benches.
- One transaction is outstanding at a time. A response-phase timeout guards against unresponsive slaves.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width (32 only; 64 rejected by elaboration assertion).
- TIMEOUT_CYCLES, 256, cycles waited for BVALID/RVALID before reporting timeout (min 2).

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_rnw  in  1  1=read, 0=write
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or SLVERR on timeout
- rsp_timeout  out  1  response produced by timeout
- busy  out  1  FSM not IDLE or stale flag set
- M_AXI_AWADDR, M_AXI_AWPROT(3), M_AXI_AWVALID out; M_AXI_AWREADY in
- M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID out; M_AXI_WREADY in
- M_AXI_BRESP(2), M_AXI_BVALID in; M_AXI_BREADY out
- M_AXI_ARADDR, M_AXI_ARPROT(3), M_AXI_ARVALID out; M_AXI_ARREADY in
- M_AXI_RDATA, M_AXI_RRESP(2), M_AXI_RVALID in; M_AXI_RREADY out

Behaviour:
- Reset values:
  - All VALID and READY outputs 0; rsp_valid 0; rsp_timeout 0; busy 0.
  - Address, data and rsp_* registers 0.
  - FSM IDLE; stale flag 0. cmd_ready is 1 from the first cycle after reset deasserts.
- AWPROT and ARPROT are constant 3'b000. All AXI outputs are registered.
- cmd_ready = (state==IDLE) && !stale. The command is latched on cmd_valid && cmd_ready (cycle 0).
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - On a write accept, enter WR_REQ; AWVALID and WVALID go high together in cycle 1.
  - On a read accept, enter RD_REQ; ARVALID goes high in cycle 1.
- WR_REQ:
  - AWVALID and WVALID each drop the cycle after their own handshake. Per-channel done flags are kept.
  - Go to WR_RESP when both channels are done, including when both handshakes occur in the same cycle.
  - No VALID is ever withdrawn before its handshake.
- WR_RESP:
  - BREADY=1. On BVALID, capture BRESP, set rdata=0, go to RSP.
- RD_REQ:
  - ARVALID held until ARREADY; then go to RD_RESP.
- RD_RESP:
  - RREADY=1. On RVALID, capture RDATA/RRESP, go to RSP.
- RSP:
  - rsp_valid=1, outputs stable until rsp_ready; then go to IDLE.
  - The next command is accepted no earlier than the cycle after the rsp handshake.
- Latency with an always-ready slave that responds one cycle after the address handshake:
  - Cycle 1 request, cycle 2 B/R beat, cycle 3 rsp_valid.
- Timeout:
  - The counter clears on entry to WR_RESP/RD_RESP and increments each cycle without BVALID/RVALID.
  - At count TIMEOUT_CYCLES-1 without a beat, the FSM goes to RSP with rsp_resp=2'b10, rsp_timeout=1, rdata=0, and sets stale.
  - A beat arriving on the same cycle as expiry wins: normal response, no stale.
  - The request phase has no timeout.
- Stale:
  - While stale, BREADY (after a write) or RREADY (after a read) stays 1 and cmd_ready=0.
  - The late beat is discarded and clears stale. A beat during RSP is absorbed too.
- Reset mid-operation: on the next edge all outputs return to reset values, regardless of pending handshakes.

Decomposition:
- Package axi_lite_pkg holds:
  - resp constants AXI_RESP_OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3;
  - the state enum axi_lite_mst_state_t;
  - a default-PROT constant.
- One natural sub-module: axi_lite_timeout_ctr (clear/enable/expire). The FSM and channel logic stay in the top.

Test Plan:
1. Write 0x00000001 to 0x0, wstrb 0xF, slave always ready, B OKAY next cycle -> AW/W valid cycle 1; rsp_valid cycle 3; resp 0, timeout 0.
2. Write 0x00000002 to 0x4 with AWREADY at cycle 1 and WREADY delayed to cycle 4 -> AWVALID low from cycle 2, WVALID held to cycle 4, BREADY from cycle 5; single correct response.
3. Read 0x8, slave returns RDATA 0xDEADBEEF with RRESP SLVERR -> rsp_rdata 0xDEADBEEF, rsp_resp 2, timeout 0.
4. TIMEOUT_CYCLES=16, write, slave never asserts BVALID -> rsp after 16 wait cycles with resp 2, timeout 1; cmd_ready stays 0. Late BVALID 5 cycles later -> absorbed; cmd_ready returns to 1.
5. Read, rsp_ready held low 10 cycles -> rsp_valid and rsp_rdata stable; cmd_ready 0 throughout.
6. Assert ARESET with AWVALID high mid-write -> next cycle all VALID/READY 0, FSM IDLE; a subsequent write to 0xC completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite command-stream master:
// response codes, protection default and the master FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } axi_lite_mst_state_t;

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Response-phase watchdog: counts idle wait cycles and flags expiry
// when the count reaches TIMEOUT_CYCLES-1.
module axi_lite_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/axi_lite_master_cmd.sv
// AXI4-Lite master turning a command/response stream into single-beat
// reads and writes, one outstanding, with a response-phase timeout.
module axi_lite_master_cmd
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

  if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi_lite_master_cmd: C_M_AXI_DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axi_lite_master_cmd: TIMEOUT_CYCLES must be at least 2");
  end

  axi_lite_mst_state_t state_q, state_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          arvalid_q, arvalid_d;
  logic          bready_q, bready_d;
  logic          rready_q, rready_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          stale_q, stale_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_resp_q, rsp_resp_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  logic aw_fire, w_fire, in_wait, beat, tmr_expire;

  assign aw_fire = awvalid_q && M_AXI_AWREADY;
  assign w_fire  = wvalid_q && M_AXI_WREADY;
  assign in_wait = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);
  assign beat    = (state_q == ST_WR_RESP) ? M_AXI_BVALID : M_AXI_RVALID;

  axi_lite_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (ACLK),
    .rst   (ARESET),
    .clear (!in_wait),
    .enable(in_wait && !beat),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    stale_d       = stale_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    // A late beat from a timed-out transaction is swallowed here.
    if (stale_q && ((bready_q && M_AXI_BVALID) || (rready_q && M_AXI_RVALID))) begin
      stale_d  = 1'b0;
      bready_d = 1'b0;
      rready_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_rnw) begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end else begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = M_AXI_BRESP;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RSP;
        end else if (tmr_expire) begin
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = AXI_RESP_SLVERR;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          stale_d       = 1'b1;
          state_d       = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = M_AXI_RRESP;
          rsp_rdata_d   = M_AXI_RDATA;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RSP;
        end else if (tmr_expire) begin
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = AXI_RESP_SLVERR;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          stale_d       = 1'b1;
          state_d       = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      stale_q       <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      stale_q       <= stale_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE) && !stale_q;
  assign busy          = (state_q != ST_IDLE) || stale_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed bench for axi_lite_master_cmd: hand-timed slave responses,
// expected values written out per cycle.
module tb_axi_lite_master_cmd;
  import axi_lite_pkg::*;

  logic        ACLK;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  axi_lite_master_cmd #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rnw      (cmd_rnw),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one command in cycle 0 and returns one edge later, in cycle 1.
  task automatic applyStimulus(input logic rnw, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    cmd_rnw   = rnw;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    cmd_valid = 1'b1;
    checkOutput("cmd_ready_c0", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    awready = 1; wready = 1; arready = 1;
    bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
    repeat (3) step();
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_timeout", rsp_timeout, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_awaddr", awaddr, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    ARESET = 1'b0;
    step();
    checkOutput("post_rst_cmd_ready", cmd_ready, 1);
    checkOutput("awprot", awprot, 0);
    checkOutput("arprot", arprot, 0);

    $display("[TB] test 1: basic write");
    applyStimulus(1'b0, 32'h0, 32'h1, 4'hF);
    checkOutput("t1_awvalid_c1", awvalid, 1);
    checkOutput("t1_wvalid_c1", wvalid, 1);
    checkOutput("t1_awaddr", awaddr, 32'h0);
    checkOutput("t1_wdata", wdata, 32'h1);
    checkOutput("t1_wstrb", wstrb, 4'hF);
    checkOutput("t1_bready_c1", bready, 0);
    checkOutput("t1_cmd_ready_c1", cmd_ready, 0);
    step();
    checkOutput("t1_awvalid_c2", awvalid, 0);
    checkOutput("t1_wvalid_c2", wvalid, 0);
    checkOutput("t1_bready_c2", bready, 1);
    bvalid = 1; bresp = AXI_RESP_OKAY;
    step();
    bvalid = 0;
    checkOutput("t1_rsp_valid_c3", rsp_valid, 1);
    checkOutput("t1_rsp_resp", rsp_resp, 0);
    checkOutput("t1_rsp_timeout", rsp_timeout, 0);
    checkOutput("t1_rsp_rdata", rsp_rdata, 0);
    checkOutput("t1_bready_c3", bready, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checkOutput("t1_rsp_valid_done", rsp_valid, 0);
    checkOutput("t1_cmd_ready_done", cmd_ready, 1);
    checkOutput("t1_busy_done", busy, 0);

    $display("[TB] test 2: write with delayed WREADY");
    wready = 0;
    applyStimulus(1'b0, 32'h4, 32'h2, 4'hF);
    checkOutput("t2_awvalid_c1", awvalid, 1);
    checkOutput("t2_wvalid_c1", wvalid, 1);
    step();
    checkOutput("t2_awvalid_c2", awvalid, 0);
    checkOutput("t2_wvalid_c2", wvalid, 1);
    checkOutput("t2_bready_c2", bready, 0);
    step();
    checkOutput("t2_wvalid_c3", wvalid, 1);
    step();
    wready = 1;
    checkOutput("t2_wvalid_c4", wvalid, 1);
    checkOutput("t2_wdata_c4", wdata, 32'h2);
    checkOutput("t2_bready_c4", bready, 0);
    step();
    checkOutput("t2_wvalid_c5", wvalid, 0);
    checkOutput("t2_bready_c5", bready, 1);
    checkOutput("t2_rsp_valid_c5", rsp_valid, 0);
    bvalid = 1; bresp = AXI_RESP_EXOKAY;
    step();
    bvalid = 0;
    checkOutput("t2_rsp_valid_c6", rsp_valid, 1);
    checkOutput("t2_rsp_resp", rsp_resp, 1);
    checkOutput("t2_bready_c6", bready, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checkOutput("t2_rsp_valid_done", rsp_valid, 0);
    step();
    checkOutput("t2_single_rsp", rsp_valid, 0);

    $display("[TB] test 3: read with SLVERR");
    applyStimulus(1'b1, 32'h8, 32'h0, 4'h0);
    checkOutput("t3_arvalid_c1", arvalid, 1);
    checkOutput("t3_araddr", araddr, 32'h8);
    checkOutput("t3_awvalid_c1", awvalid, 0);
    step();
    checkOutput("t3_arvalid_c2", arvalid, 0);
    checkOutput("t3_rready_c2", rready, 1);
    rvalid = 1; rdata = 32'hDEADBEEF; rresp = AXI_RESP_SLVERR;
    step();
    rvalid = 0; rdata = 32'h0;
    checkOutput("t3_rsp_valid_c3", rsp_valid, 1);
    checkOutput("t3_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    checkOutput("t3_rsp_resp", rsp_resp, 2);
    checkOutput("t3_rsp_timeout", rsp_timeout, 0);
    checkOutput("t3_rready_c3", rready, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checkOutput("t3_cmd_ready_done", cmd_ready, 1);

    $display("[TB] test 4: write timeout and late B beat");
    applyStimulus(1'b0, 32'h14, 32'h55, 4'h1);
    step();
    checkOutput("t4_bready_c2", bready, 1);
    repeat (15) step();
    checkOutput("t4_rsp_valid_c17", rsp_valid, 0);
    step();
    checkOutput("t4_rsp_valid_c18", rsp_valid, 1);
    checkOutput("t4_rsp_resp", rsp_resp, 2);
    checkOutput("t4_rsp_timeout", rsp_timeout, 1);
    checkOutput("t4_rsp_rdata", rsp_rdata, 0);
    checkOutput("t4_bready_rsp", bready, 1);
    checkOutput("t4_cmd_ready_rsp", cmd_ready, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checkOutput("t4_rsp_valid_after", rsp_valid, 0);
    checkOutput("t4_cmd_ready_stale", cmd_ready, 0);
    checkOutput("t4_busy_stale", busy, 1);
    checkOutput("t4_bready_stale", bready, 1);
    repeat (3) step();
    checkOutput("t4_cmd_ready_stale2", cmd_ready, 0);
    step();
    bvalid = 1; bresp = AXI_RESP_OKAY;
    step();
    bvalid = 0;
    checkOutput("t4_cmd_ready_cleared", cmd_ready, 1);
    checkOutput("t4_bready_cleared", bready, 0);
    checkOutput("t4_busy_cleared", busy, 0);
    checkOutput("t4_no_extra_rsp", rsp_valid, 0);

    $display("[TB] test 5: read with rsp backpressure");
    applyStimulus(1'b1, 32'h10, 32'h0, 4'h0);
    step();
    rvalid = 1; rdata = 32'h12345678; rresp = AXI_RESP_DECERR;
    step();
    rvalid = 0; rdata = 32'hFFFFFFFF; rresp = AXI_RESP_OKAY;
    for (int i = 0; i < 10; i++) begin
      checkOutput("t5_rsp_valid_hold", rsp_valid, 1);
      checkOutput("t5_rsp_rdata_hold", rsp_rdata, 32'h12345678);
      checkOutput("t5_rsp_resp_hold", rsp_resp, 3);
      checkOutput("t5_cmd_ready_hold", cmd_ready, 0);
      step();
    end
    rsp_ready = 1;
    checkOutput("t5_rsp_valid_last", rsp_valid, 1);
    step();
    rsp_ready = 0;
    rdata = 32'h0;
    checkOutput("t5_rsp_valid_done", rsp_valid, 0);
    checkOutput("t5_cmd_ready_done", cmd_ready, 1);

    $display("[TB] test 6: reset mid-write");
    awready = 0; wready = 0;
    applyStimulus(1'b0, 32'h20, 32'h77, 4'hF);
    checkOutput("t6_awvalid_c1", awvalid, 1);
    step();
    checkOutput("t6_awvalid_c2", awvalid, 1);
    ARESET = 1;
    step();
    checkOutput("t6_awvalid_rst", awvalid, 0);
    checkOutput("t6_wvalid_rst", wvalid, 0);
    checkOutput("t6_arvalid_rst", arvalid, 0);
    checkOutput("t6_bready_rst", bready, 0);
    checkOutput("t6_rready_rst", rready, 0);
    checkOutput("t6_busy_rst", busy, 0);
    checkOutput("t6_awaddr_rst", awaddr, 0);
    ARESET = 0; awready = 1; wready = 1;
    step();
    applyStimulus(1'b0, 32'hC, 32'hA5A5A5A5, 4'h3);
    checkOutput("t6_awaddr", awaddr, 32'hC);
    checkOutput("t6_wdata", wdata, 32'hA5A5A5A5);
    checkOutput("t6_wstrb", wstrb, 4'h3);
    step();
    bvalid = 1; bresp = AXI_RESP_OKAY;
    step();
    bvalid = 0;
    checkOutput("t6_rsp_valid", rsp_valid, 1);
    checkOutput("t6_rsp_resp", rsp_resp, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    $display("[TB] test 7: beat on the expiry cycle");
    applyStimulus(1'b0, 32'h18, 32'h9, 4'hF);
    step();
    repeat (15) step();
    checkOutput("t7_rsp_valid_c17", rsp_valid, 0);
    bvalid = 1; bresp = AXI_RESP_EXOKAY;
    step();
    bvalid = 0;
    checkOutput("t7_rsp_valid_c18", rsp_valid, 1);
    checkOutput("t7_rsp_resp", rsp_resp, 1);
    checkOutput("t7_rsp_timeout", rsp_timeout, 0);
    checkOutput("t7_bready", bready, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checkOutput("t7_cmd_ready_done", cmd_ready, 1);
    checkOutput("t7_busy_done", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
